// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: defaults, FSM encoding, control bundle.
// Latency: n/a (types and constants only); backpressure: n/a.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W_DEF  = 4;
  localparam int MEM_TIMEOUT_DEF = 255;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  typedef struct packed {
    logic pc_en;
    logic if_of_en;
    logic of_ex_en;
    logic ex_ma_en;
    logic if_of_flush;
    logic of_ex_bubble;
    logic ma_rw_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  // Whole pipe frozen, MA result replaced by a NOP.
  localparam ctrl_t CTRL_MEM_STALL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: OF sources against a load's destination in EX.
// Latency: combinational; backpressure: none.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_is_load,
  input  logic                  ex_wb_en,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  load_use
);

  // Identical rs1/rs2 collapse into one OR term, so they cost a single stall.
  assign load_use = ex_is_load & ex_wb_en &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline enables/flushes for load-use, taken branch and MA memory stall, with memory timeout.
// Latency: outputs combinational from state+inputs; memory stall freezes all stages until ma_mem_ready.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_is_load,
  input  logic                  ex_wb_en,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  ma_mem_req,
  input  logic                  ma_mem_ready,
  output logic                  pc_en,
  output logic                  if_of_en,
  output logic                  of_ex_en,
  output logic                  ex_ma_en,
  output logic                  if_of_flush,
  output logic                  of_ex_bubble,
  output logic                  ma_rw_bubble,
  output logic                  mem_timeout,
  output logic [15:0]           stall_cycles
);

  // Counter value at which the next still-waiting edge reaches MEM_TIMEOUT.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] wait_cnt;
  logic       load_use;
  logic       mem_stall;
  ctrl_t      ctrl;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_is_load  (ex_is_load),
    .ex_wb_en    (ex_wb_en),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  assign mem_stall = ma_mem_req & ~ma_mem_ready;

  always_comb begin
    ctrl      = CTRL_DEFAULT;
    state_nxt = state;
    // While reset is held the pipe sees plain defaults, whatever the inputs say.
    if (rst_n) begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            ctrl      = CTRL_MEM_STALL;
            state_nxt = ST_MEM_WAIT;
          end else if (ex_branch_taken) begin
            ctrl.if_of_flush  = 1'b1;
            ctrl.of_ex_bubble = 1'b1;
          end else if (load_use) begin
            ctrl.pc_en        = 1'b0;
            ctrl.if_of_en     = 1'b0;
            ctrl.of_ex_bubble = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (ma_mem_ready) begin
            state_nxt = ST_RUN;
          end else begin
            ctrl = CTRL_MEM_STALL;
            if (wait_cnt == TIMEOUT_LAST) state_nxt = ST_ERROR;
          end
        end
        default: ctrl = CTRL_MEM_STALL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      wait_cnt     <= 8'd0;
      stall_cycles <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_MEM_WAIT) wait_cnt <= wait_cnt + 8'd1;
      else                      wait_cnt <= 8'd0;
      if (!ctrl.pc_en && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign if_of_en     = ctrl.if_of_en;
  assign of_ex_en     = ctrl.of_ex_en;
  assign ex_ma_en     = ctrl.ex_ma_en;
  assign if_of_flush  = ctrl.if_of_flush;
  assign of_ex_bubble = ctrl.of_ex_bubble;
  assign ma_rw_bubble = ctrl.ma_rw_bubble;
  // ERROR is only left through reset, so this flag is sticky by construction.
  assign mem_timeout  = (state == ST_ERROR);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic against a rule-level model.
// Outputs are compared every negedge; inputs change 1 time unit after each posedge.
module tb_pipeline_hazard_ctrl;

  localparam int W = 4;

  typedef struct packed {
    logic pc_en;
    logic if_of_en;
    logic of_ex_en;
    logic ex_ma_en;
    logic if_of_flush;
    logic of_ex_bubble;
    logic ma_rw_bubble;
    logic mem_timeout;
  } outs_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] id_rs1, id_rs2, ex_rd;
  logic         id_uses_rs1, id_uses_rs2, ex_is_load, ex_wb_en;
  logic         ex_branch_taken, ma_mem_req, ma_mem_ready;
  logic         pc_en, if_of_en, of_ex_en, ex_ma_en;
  logic         if_of_flush, of_ex_bubble, ma_rw_bubble, mem_timeout;
  logic [15:0]  stall_cycles;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: consecutive memory-stalled cycles so far (0 = not waiting), error flag, stall count.
  int m_wait_len = 0;
  bit m_err      = 1'b0;
  int m_stalls   = 0;

  pipeline_hazard_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_is_load      (ex_is_load),
    .ex_wb_en        (ex_wb_en),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .ma_mem_req      (ma_mem_req),
    .ma_mem_ready    (ma_mem_ready),
    .pc_en           (pc_en),
    .if_of_en        (if_of_en),
    .of_ex_en        (of_ex_en),
    .ex_ma_en        (ex_ma_en),
    .if_of_flush     (if_of_flush),
    .of_ex_bubble    (of_ex_bubble),
    .ma_rw_bubble    (ma_rw_bubble),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic outs_t model_out();
    outs_t e;
    bit    lu;
    e = 8'b1111_0000;
    lu = ex_is_load && ex_wb_en &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (!rst_n) return e;
    if (m_err) begin
      e = 8'b0000_0011;
    end else if (m_wait_len > 0) begin
      if (!ma_mem_ready) e = 8'b0000_0010;
    end else if (ma_mem_req && !ma_mem_ready) begin
      e = 8'b0000_0010;
    end else if (ex_branch_taken) begin
      e.if_of_flush  = 1'b1;
      e.of_ex_bubble = 1'b1;
    end else if (lu) begin
      e.pc_en        = 1'b0;
      e.if_of_en     = 1'b0;
      e.of_ex_bubble = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    outs_t e;
    if (!rst_n) begin
      m_wait_len = 0;
      m_err      = 1'b0;
      m_stalls   = 0;
    end else begin
      e = model_out();
      if (!e.pc_en && m_stalls < 65535) m_stalls = m_stalls + 1;
      if (!m_err) begin
        if (m_wait_len > 0) begin
          if (ma_mem_ready) m_wait_len = 0;
          else begin
            m_wait_len = m_wait_len + 1;
            if (m_wait_len >= 256) m_err = 1'b1;
          end
        end else if (ma_mem_req && !ma_mem_ready) begin
          m_wait_len = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    outs_t e, a;
    if (!rst_n) begin
      m_wait_len = 0;
      m_err      = 1'b0;
      m_stalls   = 0;
    end
    e = model_out();
    a = {pc_en, if_of_en, of_ex_en, ex_ma_en, if_of_flush, of_ex_bubble, ma_rw_bubble, mem_timeout};
    n_chk = n_chk + 1;
    if (a !== e) begin
      n_fail = n_fail + 1;
      $display("FAIL model_outputs t=%0t got=%b want=%b", $time, a, e);
    end
    n_chk = n_chk + 1;
    if (stall_cycles !== 16'(m_stalls)) begin
      n_fail = n_fail + 1;
      $display("FAIL model_stall_cycles t=%0t got=%0d want=%0d", $time, stall_cycles, m_stalls);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_is_load = 1'b0; ex_wb_en = 1'b0;
    ex_branch_taken = 1'b0; ma_mem_req = 1'b0; ma_mem_ready = 1'b0;
  endtask

  task automatic set_load(input logic [W-1:0] rd);
    ex_is_load = 1'b1; ex_wb_en = 1'b1; ex_rd = rd;
  endtask

  initial begin
    quiet();
    rst_n = 1'b0;
    #2;
    chk("reset_stall_cycles", 32'(stall_cycles), 32'd0);
    chk("reset_pc_en", 32'(pc_en), 32'd1);
    chk("reset_mem_timeout", 32'(mem_timeout), 32'd0);
    step();
    rst_n = 1'b1;

    // Load-use on rs2 only.
    set_load(4'd3); id_uses_rs2 = 1'b1; id_rs2 = 4'd3; id_uses_rs1 = 1'b1; id_rs1 = 4'd5;
    @(negedge clk);
    chk("lu_pc_en", 32'(pc_en), 32'd0);
    chk("lu_if_of_en", 32'(if_of_en), 32'd0);
    chk("lu_of_ex_bubble", 32'(of_ex_bubble), 32'd1);
    step();
    quiet();
    @(negedge clk);
    chk("lu_stall_cycles", 32'(stall_cycles), 32'd1);

    // Branch beats load-use.
    step();
    set_load(4'd3); id_uses_rs2 = 1'b1; id_rs2 = 4'd3; ex_branch_taken = 1'b1;
    @(negedge clk);
    chk("br_pc_en", 32'(pc_en), 32'd1);
    chk("br_if_of_flush", 32'(if_of_flush), 32'd1);
    chk("br_of_ex_bubble", 32'(of_ex_bubble), 32'd1);
    step();
    quiet();
    @(negedge clk);
    chk("br_stall_cycles", 32'(stall_cycles), 32'd1);

    // Five-cycle memory stall.
    step();
    ma_mem_req = 1'b1; ma_mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mem_enables", 32'({pc_en, if_of_en, of_ex_en, ex_ma_en}), 32'd0);
      step();
    end
    ma_mem_ready = 1'b1;
    @(negedge clk);
    chk("mem_release_pc_en", 32'(pc_en), 32'd1);
    chk("mem_release_ma_rw_bubble", 32'(ma_rw_bubble), 32'd0);
    step();
    quiet();
    @(negedge clk);
    chk("mem_stall_cycles", 32'(stall_cycles), 32'd6);

    // Both sources name the loaded register: still one stall.
    step();
    set_load(4'd7); id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_rs1 = 4'd7; id_rs2 = 4'd7;
    @(negedge clk);
    chk("dual_pc_en", 32'(pc_en), 32'd0);
    step();
    quiet();
    @(negedge clk);
    chk("dual_stall_cycles", 32'(stall_cycles), 32'd7);

    // Asynchronous reset in the middle of a memory wait.
    step();
    ma_mem_req = 1'b1; ma_mem_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stall_cycles", 32'(stall_cycles), 32'd0);
    chk("arst_pc_en", 32'(pc_en), 32'd1);
    chk("arst_ma_rw_bubble", 32'(ma_rw_bubble), 32'd0);
    chk("arst_mem_timeout", 32'(mem_timeout), 32'd0);
    quiet();
    step();
    rst_n = 1'b1;

    // Random traffic, occasional one-cycle reset pulses.
    for (int i = 0; i < 1500; i++) begin
      step();
      rst_n           = ($urandom_range(0, 199) != 0);
      id_rs1          = W'($urandom);
      id_rs2          = W'($urandom);
      ex_rd           = W'($urandom);
      id_uses_rs1     = 1'($urandom);
      id_uses_rs2     = 1'($urandom);
      ex_is_load      = 1'($urandom);
      ex_wb_en        = ($urandom_range(0, 3) != 0);
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      ma_mem_req      = ($urandom_range(0, 3) == 0);
      ma_mem_ready    = ($urandom_range(0, 2) != 0);
    end
    step();
    rst_n = 1'b1;
    quiet();
    ma_mem_ready = 1'b1;
    step();
    step();

    // Memory never answers: ERROR after 256 waiting cycles, sticky until reset.
    ma_mem_req = 1'b1; ma_mem_ready = 1'b0;
    for (int i = 0; i < 255; i++) step();
    @(negedge clk);
    chk("to_before_limit", 32'(mem_timeout), 32'd0);
    step();
    @(negedge clk);
    chk("to_after_limit", 32'(mem_timeout), 32'd1);
    step();
    ma_mem_req = 1'b0; ma_mem_ready = 1'b1;
    repeat (10) step();
    @(negedge clk);
    chk("to_sticky", 32'(mem_timeout), 32'd1);
    chk("to_sticky_pc_en", 32'(pc_en), 32'd0);

    // Long stall saturates the counter.
    repeat (70000) step();
    @(negedge clk);
    chk("stall_saturate", 32'(stall_cycles), 32'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("final_rst_stall", 32'(stall_cycles), 32'd0);
    chk("final_rst_timeout", 32'(mem_timeout), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 4, register-specifier width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, maximum MEM_WAIT cycles before error.
REQ-003 clk  in  1  single clock; state updates on posedge, so outputs settle before the negedge latch update.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 id_rs1, id_rs2  in  REG_ADDR_W  source specifiers of the instruction in OF.
REQ-006 id_uses_rs1, id_uses_rs2  in  1  OF instruction reads rs1/rs2.
REQ-007 ex_is_load, ex_wb_en  in  1  EX instruction is a load / writes a register.
REQ-008 ex_rd  in  REG_ADDR_W  EX destination specifier.
REQ-009 ex_branch_taken  in  1  branch or jump resolved taken in EX.
REQ-010 ma_mem_req, ma_mem_ready  in  1  MA memory access pending / completes this cycle.
REQ-011 pc_en, if_of_en, of_ex_en, ex_ma_en  out  1  load enables for the PC and the IF/OF, OF/EX and EX/MA latches.
REQ-012 if_of_flush, of_ex_bubble, ma_rw_bubble  out  1  force NOP (control bus zero) into the named latch.
REQ-013 mem_timeout  out  1  sticky error flag.
REQ-014 stall_cycles  out  16  saturating count of cycles with pc_en=0.

Function
REQ-015 FSM states SHALL be RUN, MEM_WAIT and ERROR.
REQ-016 Outputs SHALL be combinational from state and inputs; default values: all enables 1, all flush/bubble outputs 0.
REQ-017 Load-use hazard = ex_is_load & ex_wb_en & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-018 RUN, load-use, no other event: pc_en=0, if_of_en=0, of_ex_bubble=1; one cycle only, because the load leaves EX.
REQ-019 RUN, ex_branch_taken: if_of_flush=1, of_ex_bubble=1, pc_en=1; this has priority over load-use.
REQ-020 RUN, ma_mem_req & !ma_mem_ready: pc_en=if_of_en=of_ex_en=ex_ma_en=0, ma_rw_bubble=1 in the same cycle; next state MEM_WAIT.
REQ-021 Memory stall has priority over branch and load-use; a held ex_branch_taken or hazard is honoured in the first cycle after the stall releases.
REQ-022 MEM_WAIT: same outputs as REQ-020 while ma_mem_ready=0; when ma_mem_ready=1, default outputs apply and next state is RUN.
REQ-023 MEM_WAIT SHALL use an 8-bit wait counter, cleared on entry and incremented each cycle; counter reaching MEM_TIMEOUT with ma_mem_ready=0 SHALL move the FSM to ERROR.
REQ-024 ERROR: all enables 0, ma_rw_bubble=1, mem_timeout=1; the FSM SHALL leave ERROR only on reset.
REQ-025 stall_cycles SHALL increment on every posedge where pc_en=0 and SHALL hold at 0xFFFF.
REQ-026 Identical rs1/rs2 specifiers SHALL produce exactly one stall cycle.

Reset
REQ-027 Asserting rst_n low SHALL immediately force state RUN, wait counter 0, stall_cycles 0 and mem_timeout 0, including mid-MEM_WAIT.
REQ-028 After release, outputs SHALL follow REQ-016 to REQ-022 from the first posedge.

Structure
REQ-029 The FSM state encoding, REG_ADDR_W and MEM_TIMEOUT defaults SHALL live in shared package pipe_ctrl_pkg.
REQ-030 The hazard comparator SHALL be one sub-module, hazard_detect, combinational, with output load_use.

Verification
REQ-031 ex_is_load=1, ex_wb_en=1, ex_rd=3, id_uses_rs2=1, id_rs2=3 -> one cycle of pc_en=0, if_of_en=0, of_ex_bubble=1; stall_cycles=1.
REQ-032 ex_branch_taken=1 with a simultaneous load-use -> if_of_flush=1, of_ex_bubble=1, pc_en=1; stall_cycles unchanged.
REQ-033 ma_mem_req=1, ma_mem_ready low for 5 cycles then high -> all enables 0 for 5 cycles, RUN on cycle 6, stall_cycles=5.
REQ-034 ma_mem_ready held low for 256 cycles -> ERROR, mem_timeout=1 held until rst_n=0.
REQ-035 rst_n=0 asserted during MEM_WAIT -> immediate RUN, default outputs, stall_cycles=0 without waiting for clk.
REQ-036 Force 70000 stall cycles -> stall_cycles saturates at 0xFFFF.
